syscall_unit: RTL and testbench
===============================

// Module: syscall_unit
// PURPOSE
//  Consumer of the register file's $v0/$a0 syscall read ports. On a decoded SYSCALL it samples
//  $v0 (service) and $a0 (argument), stalls the pipeline, and streams ASCII console bytes out
//  over a valid/ready port, or halts the core. Sits beside decode, between regfile and console/TB.
// PARAMETERS
//  HEX_UPPER  0  1: hex digits emitted as 'A'-'F'; 0: 'a'-'f'
// PORTS
//  clk            in   1   system clock, all state updates on posedge
//  rst            in   1   asynchronous, active-low reset
//  syscall_valid  in   1   SYSCALL instruction present in decode this cycle
//  pc             in   32  address of that SYSCALL instruction
//  v0_data        in   32  $v0 value (service number), already write-forwarded
//  a0_data        in   32  $a0 value (argument), already write-forwarded
//  stall          out  1   hold fetch/decode while high
//  halted         out  1   exit service executed; sticky until reset
//  out_valid      out  1   console byte available
//  out_data       out  8   ASCII byte
//  out_ready      in   1   console accepts byte when out_valid & out_ready at posedge
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; stall=0, halted=0, out_valid=0, out_data=8'h00.
//  Services ($v0): 1 print signed decimal of $a0; 11 print char $a0[7:0]; 34 print "0x"+8 hex
//   digits of $a0, leading zeros kept; 10 exit; any other value = no-op.
//  stall = (state!=IDLE && state!=DONE && state!=HALT) | (state==IDLE & syscall_valid & !halted).
//  States: IDLE, SIGN, DIGIT, EMIT, DONE, HALT.
//   IDLE: syscall_valid=1 -> latch v0/a0/pc. 10->HALT (halted=1 next cycle); 11->EMIT(char);
//     34->EMIT('0','x', then nibbles 7..0); 1 with a0[31]=1->SIGN, else DIGIT with k=9;
//     unknown->DONE.
//   SIGN: emit '-' (wait for handshake), mag = -a0 as unsigned -> DIGIT k=9.
//   DIGIT: one compare/subtract per cycle: if mag>=POW10[k] {mag-=POW10[k]; d++}, else digit
//     final: emit '0'+d if d!=0 | started | k==0, set started; k==0 -> DONE after emit, else k--.
//   EMIT: out_valid=1, out_data stable until out_ready; byte retires at handshake edge; no
//     bubble required between consecutive bytes of one service.
//   DONE: one cycle, stall=0, syscall_valid ignored (same instruction still in decode) -> IDLE.
//   HALT: absorbing; stall=0, further syscalls ignored, no output.
//  Width rules: mag is 32-bit unsigned; -2147483648 -> magnitude 32'h8000_0000 prints
//   "-2147483648". 0 prints "0". Hex nibble n -> '0'+n (n<10) else 'a'/'A'+n-10.
//  out_valid never drops without handshake except by reset. Reset mid-stream abandons the
//   service with no partial-byte glitch; out_valid low asynchronously.
//  Bound: print-int finishes within 10*10 + 11 bytes' handshakes + 2 cycles.
// CONFIGURATION
//  SYSCALL_TRACE_EN defined: at IDLE acceptance, $display("@%08h: syscall $v0=%0d $a0=%08h",
//   pc, v0, a0), and on exit $display("@%08h: exit"). Undefined: no $display, logic identical.
// STRUCTURE
//  Package syscall_pkg: SVC_PRINT_INT=1, SVC_EXIT=10, SVC_PRINT_CHAR=11, SVC_PRINT_HEX=34;
//   state encoding; POW10[0:9] 32-bit table; ASCII_0, ASCII_MINUS, ASCII_X constants.
//  Sub-module syscall_bin2dec: serial subtract-based digit generator (load, step, digit, done),
//   owning mag/k/d/started; top keeps FSM and output register.
// TESTING
//  v0=1,a0=32'd1234, out_ready=1 -> bytes "1234", stall high throughout, DONE then stall=0.
//  v0=1,a0=32'h8000_0000 -> "-2147483648"; v0=1,a0=0 -> "0"; a0=-7 -> "-7".
//  v0=34,a0=32'h00AB_01CF, HEX_UPPER=0 -> "0x00ab01cf"; out_ready toggled 1-0 -> data stable.
//  v0=11,a0=32'h0000_0141 -> single byte 8'h41; v0=5 -> no bytes, stall 1 cycle, DONE.
//  v0=10 -> halted=1 next cycle, stall=0; later syscall_valid with v0=1 -> no output.
//  rst=0 mid-"1234" after "12" -> out_valid=0 immediately; after release new v0=11 works.

Source files
------------

// File: rtl/syscall_pkg.sv
// Shared constants for the syscall unit: service numbers, FSM encoding,
// the decimal power table and the ASCII bytes the console stream is built from.
package syscall_pkg;

    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SVC_PRINT_HEX  = 32'd34;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2d;
    localparam logic [7:0] ASCII_X     = 8'h78;

    localparam logic [31:0] POW10 [0:9] = '{
        32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000,
        32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_SIGN, ST_DIGIT, ST_EMIT, ST_DONE, ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        MODE_CHAR, MODE_HEX, MODE_DEC
    } mode_t;

    // Byte idx of the hex stream: 0 -> '0', 1 -> 'x', 2..9 -> nibbles 7..0.
    function automatic logic [7:0] hex_byte(input logic [31:0] val,
                                            input logic [3:0]  idx,
                                            input logic        upper);
        logic [31:0] sh;
        logic [3:0]  n;
        sh = val << {idx - 4'd2, 2'b00};
        n  = sh[31:28];
        if (idx == 4'd0)
            hex_byte = ASCII_0;
        else if (idx == 4'd1)
            hex_byte = ASCII_X;
        else if (n < 4'd10)
            hex_byte = ASCII_0 + {4'd0, n};
        else
            hex_byte = (upper ? 8'h41 : 8'h61) + {4'd0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/syscall_bin2dec.sv
// Serial binary-to-decimal digit generator: one compare/subtract per step,
// walking powers of ten from 10^9 down to 10^0 and suppressing leading zeros.
module syscall_bin2dec
    import syscall_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    input  logic        next,
    output logic        digit_final,
    output logic        digit_emit,
    output logic [3:0]  digit_val,
    output logic        digit_last
);

    logic [31:0] mag;
    logic [3:0]  k;
    logic [3:0]  d;
    logic        started;

    assign digit_final = (mag < POW10[k]);
    assign digit_emit  = (d != 4'd0) || started || (k == 4'd0);
    assign digit_val   = d;
    assign digit_last  = (k == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag     <= 32'd0;
            k       <= 4'd9;
            d       <= 4'd0;
            started <= 1'b0;
        end else if (load) begin
            mag     <= load_val;
            k       <= 4'd9;
            d       <= 4'd0;
            started <= 1'b0;
        end else if (step) begin
            mag <= mag - POW10[k];
            d   <= d + 4'd1;
        end else if (next) begin
            d       <= 4'd0;
            started <= started || digit_emit;
            if (k != 4'd0)
                k <= k - 4'd1;
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// Syscall service unit: stalls decode and streams console bytes for print services,
// or halts the core. Define SYSCALL_TRACE_EN to log accepted syscalls.
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int HEX_UPPER = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_valid,
    input  logic [31:0] pc,
    input  logic [31:0] v0_data,
    input  logic [31:0] a0_data,
    output logic        stall,
    output logic        halted,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    state_t      state;
    mode_t       mode;
    logic [31:0] a0_q;
    logic [3:0]  hex_idx;
    logic        dec_last;
    logic        accept;

    logic        digit_final, digit_emit, digit_last;
    logic [3:0]  digit_val;

    assign accept = (state == ST_IDLE) && syscall_valid && !halted;
    assign stall  = (state == ST_SIGN) || (state == ST_DIGIT) || (state == ST_EMIT) || accept;

    syscall_bin2dec u_bin2dec (
        .clk         (clk),
        .rst         (rst),
        .load        (accept && (v0_data == SVC_PRINT_INT)),
        .load_val    (a0_data[31] ? (32'd0 - a0_data) : a0_data),
        .step        ((state == ST_DIGIT) && !digit_final),
        .next        ((state == ST_DIGIT) && digit_final),
        .digit_final (digit_final),
        .digit_emit  (digit_emit),
        .digit_val   (digit_val),
        .digit_last  (digit_last)
    );

    // Byte stream protocol: out_data is held while out_valid is high and only
    // retires on the edge where out_valid & out_ready; out_valid never falls otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mode      <= MODE_CHAR;
            a0_q      <= 32'd0;
            hex_idx   <= 4'd0;
            dec_last  <= 1'b0;
            halted    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a0_q <= a0_data;
                        case (v0_data)
                            SVC_EXIT: begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end
                            SVC_PRINT_CHAR: begin
                                state     <= ST_EMIT;
                                mode      <= MODE_CHAR;
                                out_valid <= 1'b1;
                                out_data  <= a0_data[7:0];
                            end
                            SVC_PRINT_HEX: begin
                                state     <= ST_EMIT;
                                mode      <= MODE_HEX;
                                hex_idx   <= 4'd0;
                                out_valid <= 1'b1;
                                out_data  <= ASCII_0;
                            end
                            SVC_PRINT_INT: begin
                                mode <= MODE_DEC;
                                if (a0_data[31]) begin
                                    state     <= ST_SIGN;
                                    out_valid <= 1'b1;
                                    out_data  <= ASCII_MINUS;
                                end else begin
                                    state <= ST_DIGIT;
                                end
                            end
                            default: state <= ST_DONE;
                        endcase
                    end
                end
                ST_SIGN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_DIGIT;
                    end
                end
                ST_DIGIT: begin
                    if (digit_final && digit_emit) begin
                        out_valid <= 1'b1;
                        out_data  <= ASCII_0 + {4'd0, digit_val};
                        dec_last  <= digit_last;
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        case (mode)
                            MODE_HEX: begin
                                if (hex_idx == 4'd9) begin
                                    out_valid <= 1'b0;
                                    state     <= ST_DONE;
                                end else begin
                                    hex_idx  <= hex_idx + 4'd1;
                                    out_data <= hex_byte(a0_q, hex_idx + 4'd1, HEX_UPPER != 0);
                                end
                            end
                            MODE_DEC: begin
                                out_valid <= 1'b0;
                                state     <= dec_last ? ST_DONE : ST_DIGIT;
                            end
                            default: begin
                                out_valid <= 1'b0;
                                state     <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SYSCALL_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            $display("@%08h: syscall $v0=%0d $a0=%08h", pc, v0_data, a0_data);
            if (v0_data == SVC_EXIT)
                $display("@%08h: exit", pc);
        end
    end
`else
    logic pc_unused;
    assign pc_unused = ^pc;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: a scoreboard queue of expected console bytes
// checked by a monitor on every out_valid/out_ready handshake.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        syscall_valid = 1'b0;
    logic [31:0] pc = 32'h0040_0000;
    logic [31:0] v0_data = 32'd0;
    logic [31:0] a0_data = 32'd0;
    logic        stall, halted, out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic       toggle_en = 1'b0;

    syscall_unit #(.HEX_UPPER(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .syscall_valid (syscall_valid),
        .pc            (pc),
        .v0_data       (v0_data),
        .a0_data       (a0_data),
        .stall         (stall),
        .halted        (halted),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 2ms");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back(s[i]);
    endtask

    // out_ready driver: held high, or toggling every cycle when toggle_en
    always @(posedge clk) begin
        #1;
        out_ready = toggle_en ? ~out_ready : 1'b1;
    end

    // monitor: pops on handshake, checks hold-stability while stalled by out_ready
    logic       pend = 1'b0;
    logic [7:0] pend_data = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                checks++;
                if (!out_valid || out_data !== pend_data) begin
                    failures++;
                    $display("FAIL hold_stable: got valid=%0b data=%02h expected valid=1 data=%02h",
                             out_valid, out_data, pend_data);
                end
            end
            if (out_valid && out_ready) begin
                pend = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_byte: got unexpected %02h expected no byte", out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        failures++;
                        $display("FAIL out_byte: got %02h expected %02h", out_data, e);
                    end
                end
            end else if (out_valid) begin
                pend      = 1'b1;
                pend_data = out_data;
            end else begin
                pend = 1'b0;
            end
        end
    end

    // driver: present a syscall, hold it while stalled, count stalled cycles
    task automatic run_svc(input logic [31:0] v0, input logic [31:0] a0, output int ncyc);
        @(posedge clk); #1;
        pc            = pc + 32'd4;
        v0_data       = v0;
        a0_data       = a0;
        syscall_valid = 1'b1;
        ncyc          = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!stall) break;
            ncyc++;
        end
        if (ncyc >= 400)
            check("svc_timeout", 32'(ncyc), 32'd0);
        check("svc_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        syscall_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        syscall_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
    endtask

    int n;

    initial begin
        rst = 1'b0;
        #13;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        do_reset();

        push_str("1234");
        run_svc(32'd1, 32'd1234, n);
        check("int_1234_stalled", 32'(n > 4), 32'd1);

        push_str("-2147483648");
        run_svc(32'd1, 32'h8000_0000, n);
        check("int_min_bound", 32'(n <= 111), 32'd1);

        push_str("0");
        run_svc(32'd1, 32'd0, n);

        push_str("-7");
        run_svc(32'd1, 32'hFFFF_FFF9, n);

        toggle_en = 1'b1;
        push_str("0x00ab01cf");
        run_svc(32'd34, 32'h00AB_01CF, n);
        toggle_en = 1'b0;

        push_str("A");
        run_svc(32'd11, 32'h0000_0141, n);

        run_svc(32'd5, 32'd99, n);
        check("noop_stall_cycles", 32'(n), 32'd1);

        // reset in the middle of "1234" once "12" has been accepted
        push_str("1234");
        @(posedge clk); #1;
        v0_data = 32'd1;
        a0_data = 32'd1234;
        syscall_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 2 && out_valid) break;
            n++;
        end
        check("mid_reached_3", 32'(n < 200), 32'd1);
        check("mid_presenting_3", 32'(out_data), 32'h33);
        rst = 1'b0;
        syscall_valid = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'h00);
        check("mid_rst_stall", 32'(stall), 32'd0);
        do_reset();
        push_str("B");
        run_svc(32'd11, 32'h0000_0042, n);

        run_svc(32'd10, 32'd0, n);
        check("exit_stall_cycles", 32'(n), 32'd1);
        check("exit_halted", 32'(halted), 32'd1);
        run_svc(32'd1, 32'd55, n);
        check("halt_ignores_stall", 32'(n), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_no_output", 32'(out_valid), 32'd0);

        do_reset();
        #1;
        check("halt_cleared", 32'(halted), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
